// File: rtl/mem_datos_param.sv
// Byte-addressed data memory with configurable access latency behind a
// single-outstanding valid/ready request/response handshake.
module mem_datos_param #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_fault_o
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_fault_q;

   logic [31:0]       mem_q [DEPTH];

   // Effective request: live inputs while idle (needed when LATENCY=1 commits
   // on the accept edge), captured copy otherwise.
   logic              eff_write;
   logic [1:0]        eff_size;
   logic              eff_uns;
   logic [ADDR_W-1:0] eff_addr;
   logic [31:0]       eff_wdata;
   logic [1:0]        lane;
   logic [31:0]       word_idx;
   logic [IdxW-1:0]   mem_idx;
   logic              commit;
   logic              fault;
   logic [3:0]        be;
   logic [31:0]       wdata_rep;
   logic [31:0]       rd_word;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       load_data;
   logic              mem_we;

   always_comb begin
      if (state_q == StIdle) begin
         eff_write = req_write_i;
         eff_size  = req_size_i;
         eff_uns   = req_unsigned_i;
         eff_addr  = req_addr_i;
         eff_wdata = req_wdata_i;
      end else begin
         eff_write = wr_q;
         eff_size  = size_q;
         eff_uns   = uns_q;
         eff_addr  = addr_q;
         eff_wdata = wdata_q;
      end
   end

   assign lane     = eff_addr[1:0];
   assign word_idx = 32'(eff_addr[ADDR_W-1:2]);
   assign mem_idx  = word_idx[IdxW-1:0];

   assign commit = ((state_q == StIdle) && req_valid_i && (LATENCY == 1)) ||
                   ((state_q == StBusy) && (cnt_q == 4'd1));

   always_comb begin
      fault = 1'b0;
      case (eff_size)
         2'b00:   fault = 1'b0;
         2'b01:   fault = lane[0];
         2'b10:   fault = (lane != 2'b00);
         default: fault = 1'b1;
      endcase
      if (word_idx >= DEPTH) fault = 1'b1;
   end

   always_comb begin
      be        = 4'b0000;
      wdata_rep = eff_wdata;
      case (eff_size)
         2'b00: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{eff_wdata[7:0]}};
         end
         2'b01: begin
            be        = 4'b0011 << {lane[1], 1'b0};
            wdata_rep = {2{eff_wdata[15:0]}};
         end
         2'b10: begin
            be        = 4'b1111;
            wdata_rep = eff_wdata;
         end
         default: begin
            be        = 4'b0000;
            wdata_rep = eff_wdata;
         end
      endcase
   end

   assign rd_word = mem_q[mem_idx];

   always_comb begin
      byte_v = rd_word[7:0];
      case (lane)
         2'b00: byte_v = rd_word[7:0];
         2'b01: byte_v = rd_word[15:8];
         2'b10: byte_v = rd_word[23:16];
         2'b11: byte_v = rd_word[31:24];
         default: byte_v = rd_word[7:0];
      endcase
      half_v = lane[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      load_data = rd_word;
      case (eff_size)
         2'b00:   load_data = {{24{~eff_uns & byte_v[7]}}, byte_v};
         2'b01:   load_data = {{16{~eff_uns & half_v[15]}}, half_v};
         default: load_data = rd_word;
      endcase
   end

   assign mem_we = commit && eff_write && !fault;

   // Storage is deliberately not reset; only the write is suppressed under reset.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         wr_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_fault_q <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_fault_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  wr_q    <= req_write_i;
                  size_q  <= req_size_i;
                  uns_q   <= req_unsigned_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  if (LATENCY == 1) begin
                     state_q <= StResp;
                  end else begin
                     state_q <= StBusy;
                     cnt_q   <= 4'(LATENCY - 1);
                  end
               end
            end
            StBusy: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= StResp;
            end
            StResp: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         if (commit) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= fault;
            resp_rdata_q <= (fault || eff_write) ? 32'd0 : load_data;
         end
      end
   end

   assign req_ready_o  = (state_q == StIdle);
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_fault_o = resp_fault_q;

endmodule

// File: tb/tb_mem_datos_param.sv
// Bench for mem_datos_param: directed vector table, hand-written handshake and
// reset sequences, and randomized accesses against a byte-array model.
module tb_mem_datos_param;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_fault;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] ref_mem [0:1023];

   typedef struct {
      logic          w;
      logic [1:0]    sz;
      logic          u;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      logic [31:0]   exp_rd;
      logic          exp_f;
   } vec_t;

   vec_t vecs [22];

   always #5 clk = ~clk;

   mem_datos_param #(
      .DEPTH  (DEPTH),
      .ADDR_W (AW),
      .LATENCY(LAT)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_write_i   (req_write),
      .req_size_i    (req_size),
      .req_unsigned_i(req_unsigned),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .resp_valid_o  (resp_valid),
      .resp_rdata_o  (resp_rdata),
      .resp_fault_o  (resp_fault)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                      input logic [AW-1:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic f);
      int edges;
      int ready_bad;
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = w;
      req_size     = sz;
      req_unsigned = u;
      req_addr     = a;
      req_wdata    = wd;
      @(posedge clk);
      #1;
      // Scramble the bus so only the captured request can matter.
      req_valid    = 1'b0;
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = AW'($urandom);
      req_wdata    = $urandom;
      edges        = 0;
      ready_bad    = 0;
      while (!resp_valid && edges < 20) begin
         if (req_ready) ready_bad++;
         @(posedge clk);
         #1;
         edges++;
      end
      if (req_ready) ready_bad++;
      rd = resp_rdata;
      f  = resp_fault;
      chk("latency", 32'(edges), 32'(LAT - 1));
      chk("ready_low_while_busy", 32'(ready_bad), 32'd0);
      @(posedge clk);
      #1;
      chk("after_resp_valid_ready", 32'({resp_valid, req_ready}), 32'b01);
      chk("after_resp_rdata", resp_rdata, 32'd0);
   endtask

   task automatic model_txn(input logic w, input logic [1:0] sz, input logic u,
                            input logic [AW-1:0] a, input logic [31:0] wd);
      int n;
      logic f_exp;
      logic [31:0] rd_exp;
      logic [31:0] rd;
      logic f;
      n      = 1 << sz;
      rd_exp = 32'd0;
      f_exp  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
               ((int'(a) / 4) >= int'(DEPTH));
      if (!f_exp && !w) begin
         for (int i = 0; i < n; i++) rd_exp |= 32'(ref_mem[int'(a) + i]) << (8 * i);
         if (!u && n < 4 && rd_exp[8*n-1]) rd_exp |= 32'hFFFF_FFFF << (8 * n);
      end
      txn(w, sz, u, a, wd, rd, f);
      if (!f_exp && w) begin
         for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
      end
      chk($sformatf("rand_rdata w=%0d sz=%0d u=%0d a=%03h", w, sz, u, a), rd, rd_exp);
      chk($sformatf("rand_fault w=%0d sz=%0d u=%0d a=%03h", w, sz, u, a), 32'(f), 32'(f_exp));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic f;
      int pulses;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 2'd0, 1'b0, 11'h011, 32'hAAAAAA80, 32'h00000000, 1'b0};
      vecs[3]  = '{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'hDEAD80EF, 1'b0};
      vecs[4]  = '{1'b0, 2'd0, 1'b0, 11'h011, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[5]  = '{1'b0, 2'd0, 1'b1, 11'h011, 32'h0,        32'h00000080, 1'b0};
      vecs[6]  = '{1'b1, 2'd1, 1'b0, 11'h012, 32'hFFFF1234, 32'h00000000, 1'b0};
      vecs[7]  = '{1'b0, 2'd1, 1'b0, 11'h012, 32'h0,        32'h00001234, 1'b0};
      vecs[8]  = '{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'h123480EF, 1'b0};
      vecs[9]  = '{1'b1, 2'd1, 1'b0, 11'h013, 32'h0000BBBB, 32'h00000000, 1'b1};
      vecs[10] = '{1'b1, 2'd2, 1'b0, 11'h012, 32'hCAFEF00D, 32'h00000000, 1'b1};
      vecs[11] = '{1'b0, 2'd3, 1'b0, 11'h010, 32'h0,        32'h00000000, 1'b1};
      vecs[12] = '{1'b0, 2'd2, 1'b0, 11'h400, 32'h0,        32'h00000000, 1'b1};
      vecs[13] = '{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'h123480EF, 1'b0};
      vecs[14] = '{1'b1, 2'd1, 1'b0, 11'h010, 32'h00008001, 32'h00000000, 1'b0};
      vecs[15] = '{1'b0, 2'd1, 1'b0, 11'h010, 32'h0,        32'hFFFF8001, 1'b0};
      vecs[16] = '{1'b0, 2'd1, 1'b1, 11'h010, 32'h0,        32'h00008001, 1'b0};
      vecs[17] = '{1'b0, 2'd0, 1'b0, 11'h013, 32'h0,        32'h00000012, 1'b0};
      vecs[18] = '{1'b1, 2'd2, 1'b0, 11'h3FC, 32'hA5A50001, 32'h00000000, 1'b0};
      vecs[19] = '{1'b0, 2'd2, 1'b0, 11'h3FC, 32'h0,        32'hA5A50001, 1'b0};
      vecs[20] = '{1'b0, 2'd0, 1'b1, 11'h7FF, 32'h0,        32'h00000000, 1'b1};
      vecs[21] = '{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'h12348001, 1'b0};

      rst          = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_fault", 32'(resp_fault), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         txn(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, f);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_fault", i), 32'(f), 32'(vecs[i].exp_f));
      end

      // Continuous req_valid: only requests presented while idle are taken.
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         req_valid    = (k < 9);
         req_unsigned = 1'b0;
         req_size     = 2'd2;
         if (k % (LAT + 1) == 0) begin
            req_write = 1'b0;
            req_addr  = 11'h010;
            req_wdata = 32'd0;
         end else begin
            req_write = 1'b1;
            req_addr  = 11'h010 + 11'(4 * (k % 3));
            req_wdata = 32'hBAD00000 | 32'(k);
         end
         @(posedge clk);
         #1;
         if (resp_valid) begin
            pulses++;
            chk($sformatf("hold_valid_rdata_k%0d", k), resp_rdata, 32'h12348001);
            chk($sformatf("hold_valid_fault_k%0d", k), 32'(resp_fault), 32'd0);
         end
      end
      chk("hold_valid_pulses", 32'(pulses), 32'd3);
      txn(1'b0, 2'd2, 1'b0, 11'h010, 32'd0, rd, f);
      chk("hold_valid_word_intact", rd, 32'h12348001);

      // Reset while a store is in BUSY.
      txn(1'b1, 2'd2, 1'b0, 11'h020, 32'h0, rd, f);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'd2;
      req_addr  = 11'h020;
      req_wdata = 32'h55555555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rst_mid_busy_ready_before", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy_ready_now", 32'(req_ready), 32'd1);
      pulses = 0;
      if (resp_valid) pulses++;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (resp_valid) pulses++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (resp_valid) pulses++;
      end
      chk("rst_mid_busy_no_resp", 32'(pulses), 32'd0);
      txn(1'b0, 2'd2, 1'b0, 11'h020, 32'd0, rd, f);
      chk("rst_mid_busy_store_dropped", rd, 32'h00000000);

      // Randomized region: initialise words 0..31, then mixed accesses.
      for (int wi = 0; wi < 32; wi++) model_txn(1'b1, 2'd2, 1'b0, 11'(4 * wi), $urandom);
      for (int r = 0; r < 150; r++) begin
         logic [1:0] sz;
         logic [AW-1:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         sz  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
         if ($urandom_range(0, 9) == 0) a = 11'(32'h400 + $urandom_range(0, 32'h3FF));
         else a = 11'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~11'((1 << sz) - 1);
         model_txn(1'($urandom), sz, 1'($urandom), a, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
